raw_readout: RTL and testbench



---
 rtl/raw_readout.sv | 163 ++++++++++++++++
 tb/tb_raw_readout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/raw_readout.sv
// Reader for the 192-bit raw hit delay buffer: fetches a window of bins on request
// and streams each bin as twelve 16-bit words behind a header word.
//
// state | meaning
// IDLE  | waiting for start; busy low
// HDR   | header word presented, waiting for acceptance
// FETCH | rd_adr driven with the current bin address
// LOAD  | rd_data captured into the shift register
// SEND  | presenting shift register [15:0], one word per acceptance
// DONE  | one-cycle done pulse, then back to IDLE

module raw_readout (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   start_adr,
   input  logic [4:0]   nbins,
   output logic [7:0]   rd_adr,
   input  logic [191:0] rd_data,
   output logic [15:0]  dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         dout_last,
   output logic         busy,
   output logic         done
);

   localparam int         NWORDS    = 12;
   localparam logic [3:0] HDR_TAG   = 4'hD;
   localparam logic [3:0] LAST_WORD = 4'(NWORDS - 1);
   localparam logic [3:0] PREV_WORD = 4'(NWORDS - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_FETCH,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     addr_q, addr_d;
   logic [5:0]     bins_q, bins_d;
   logic [3:0]     word_cnt_q, word_cnt_d;
   logic [191:0]   shreg_q, shreg_d;
   logic [7:0]     rd_adr_q, rd_adr_d;
   logic           dout_valid_q, dout_valid_d;
   logic           dout_last_q, dout_last_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           accept;

   // The header word also travels through the shift register so dout is a single flop source.
   assign dout       = shreg_q[15:0];
   assign rd_adr     = rd_adr_q;
   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign accept     = dout_valid_q & dout_ready;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      bins_d       = bins_q;
      word_cnt_d   = word_cnt_q;
      shreg_d      = shreg_q;
      rd_adr_d     = rd_adr_q;
      dout_valid_d = dout_valid_q;
      dout_last_d  = dout_last_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               addr_d       = start_adr;
               bins_d       = (nbins == 5'd0) ? 6'd32 : {1'b0, nbins};
               shreg_d      = {176'd0, HDR_TAG, 6'd0, bins_d};
               dout_valid_d = 1'b1;
               dout_last_d  = 1'b0;
               busy_d       = 1'b1;
               state_d      = S_HDR;
            end
         end
         S_HDR: begin
            if (accept) begin
               rd_adr_d     = addr_q;
               dout_valid_d = 1'b0;
               state_d      = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            shreg_d      = rd_data;
            word_cnt_d   = 4'd0;
            addr_d       = addr_q + 8'd1;
            dout_valid_d = 1'b1;
            dout_last_d  = 1'b0;
            state_d      = S_SEND;
         end
         S_SEND: begin
            if (accept) begin
               shreg_d = shreg_q >> 16;
               if (word_cnt_q == LAST_WORD) begin
                  bins_d       = bins_q - 6'd1;
                  dout_valid_d = 1'b0;
                  dout_last_d  = 1'b0;
                  if (bins_q == 6'd1) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     rd_adr_d = addr_q;
                     state_d  = S_FETCH;
                  end
               end else begin
                  word_cnt_d  = word_cnt_q + 4'd1;
                  dout_last_d = (word_cnt_q == PREV_WORD) && (bins_q == 6'd1);
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d       = 1'b0;
            dout_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= 8'd0;
         bins_q       <= 6'd0;
         word_cnt_q   <= 4'd0;
         shreg_q      <= 192'd0;
         rd_adr_q     <= 8'd0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         bins_q       <= bins_d;
         word_cnt_q   <= word_cnt_d;
         shreg_q      <= shreg_d;
         rd_adr_q     <= rd_adr_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_raw_readout.sv
// Scoreboard bench for raw_readout: a buffer model feeds rd_data, expected words are
// queued per request and a negedge monitor compares every accepted word.

module tb_raw_readout;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   start_adr = 8'd0;
   logic [4:0]   nbins = 5'd0;
   logic [7:0]   rd_adr;
   logic [191:0] rd_data;
   logic [15:0]  dout;
   logic         dout_valid;
   logic         dout_ready = 1'b1;
   logic         dout_last;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   raw_readout dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_adr  (start_adr),
      .nbins      (nbins),
      .rd_adr     (rd_adr),
      .rd_data    (rd_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .busy       (busy),
      .done       (done)
   );

   logic [191:0] mem [256];
   always @(posedge clk) rd_data <= mem[rd_adr];

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic        hdr;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   ready_mode = 0;
   int   exp_span = 0;
   int   acc_words = 0;
   int   hdr_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         dout_ready = (ready_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   initial begin : monitor
      logic        last_acc_prev;
      logic        stalled;
      logic [15:0] held_d;
      logic        held_l;
      exp_t        e;
      last_acc_prev = 1'b0;
      stalled       = 1'b0;
      held_d        = '0;
      held_l        = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done || last_acc_prev) check("done_pulse", {31'd0, done}, {31'd0, last_acc_prev});
         last_acc_prev = 1'b0;
         if (stalled && rst_n) begin
            check("stall_valid", {31'd0, dout_valid}, 32'd1);
            check("stall_data", {16'd0, dout}, {16'd0, held_d});
            check("stall_last", {31'd0, dout_last}, {31'd0, held_l});
         end
         stalled = dout_valid && !dout_ready && rst_n;
         held_d  = dout;
         held_l  = dout_last;
         if (dout_valid && dout_ready && rst_n) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected no word (t=%0t)", dout, $time);
            end else begin
               e = q.pop_front();
               check("word_data", {16'd0, dout}, {16'd0, e.data});
               check("word_last", {31'd0, dout_last}, {31'd0, e.last});
               if (e.hdr) hdr_cyc = cyc;
               else if (acc_words == 1 && exp_span != 0)
                  check("first_data_latency", cyc - hdr_cyc, 32'd3);
               acc_words++;
               if (e.last) begin
                  last_acc_prev = 1'b1;
                  if (exp_span != 0) check("readout_span", cyc - hdr_cyc + 1, exp_span);
               end
            end
         end
      end
   end

   task automatic push_expected(input logic [7:0] adr, input logic [4:0] nb);
      int         nbe;
      logic [5:0] nbe6;
      logic [7:0] a;
      logic [191:0] bin;
      nbe  = (nb == 5'd0) ? 32 : int'(nb);
      nbe6 = 6'(nbe);
      q.push_back('{data: {4'hD, 6'd0, nbe6}, last: 1'b0, hdr: 1'b1});
      for (int b = 0; b < nbe; b++) begin
         a   = adr + 8'(b);
         bin = mem[a];
         for (int w = 0; w < 12; w++)
            q.push_back('{data: bin[16*w +: 16], last: (b == nbe - 1 && w == 11), hdr: 1'b0});
      end
   endtask

   task automatic issue_start(input logic [7:0] adr, input logic [4:0] nb);
      @(posedge clk);
      #1;
      start     = 1'b1;
      start_adr = adr;
      nbins     = nb;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("hdr_valid_after_start", {31'd0, dout_valid}, 32'd1);
      check("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic run(input logic [7:0] adr, input logic [4:0] nb, input int mode,
                      input int span, input bit poke_busy, input bit poke_done);
      bit got;
      ready_mode = mode;
      exp_span   = span;
      acc_words  = 0;
      push_expected(adr, nb);
      issue_start(adr, nb);
      if (poke_busy) begin
         repeat (4) @(posedge clk);
         #1;
         start     = 1'b1;
         start_adr = ~adr;
         nbins     = 5'd7;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);
      check("idle_no_valid", {31'd0, dout_valid}, 32'd0);
      ready_mode = 0;
      exp_span   = 0;
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: got timeout expected $finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit got;
      for (int i = 0; i < 256; i++)
         mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mem[8'h10] = 192'h0123_4567_89AB_CDEF_0011_2233_4455_6677_7654_3210_FEDC_BA98;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, dout_valid}, 32'd0);
      check("rst_dout", {16'd0, dout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rd_adr", {24'd0, rd_adr}, 32'd0);
      check("rst_last", {31'd0, dout_last}, 32'd0);
      rst_n = 1'b1;

      run(8'h10, 5'd1, 0, 15, 1'b0, 1'b0);
      run(8'h00, 5'd0, 0, 449, 1'b0, 1'b0);
      run(8'd250, 5'd10, 0, 141, 1'b0, 1'b0);
      run(8'($urandom), 5'd3, 1, 0, 1'b0, 1'b0);
      run(8'h40, 5'd2, 1, 0, 1'b1, 1'b1);

      ready_mode = 0;
      acc_words  = 0;
      push_expected(8'h20, 5'd3);
      issue_start(8'h20, 5'd3);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (acc_words >= 15) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL reset_wait_timeout: got %0d words expected 15", acc_words);
      end
      rst_n = 1'b0;
      q.delete();
      @(posedge clk);
      #1;
      check("midrst_valid", {31'd0, dout_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_rd_adr", {24'd0, rd_adr}, 32'd0);
      check("midrst_last", {31'd0, dout_last}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run(8'h80, 5'd2, 0, 29, 1'b0, 1'b0);

      for (int k = 0; k < 3; k++)
         run(8'($urandom), 5'($urandom_range(1, 4)), 1, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
